// File: rtl/fifo8_lag_probe.sv
// Lag probe for a sample delay line: sends a marker after optional filler and times its return.
// Define FIFO8_LAG_PROBE_PRIME_EN to flush the path with 2^LAG_WIDTH filler samples before the marker.
module fifo8_lag_probe #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    LAG_WIDTH  = 7,
   parameter logic [DATA_WIDTH-1:0] MARKER     = 8'hA5,
   parameter logic [DATA_WIDTH-1:0] FILL       = 8'h00
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  tick,
   output logic [DATA_WIDTH-1:0] probe_data,
   output logic                  probe_valid,
   input  logic [DATA_WIDTH-1:0] echo_data,
   input  logic                  echo_valid,
   output logic [LAG_WIDTH-1:0]  lag,
   output logic                  lag_valid,
   output logic                  timeout,
   output logic                  busy
);

   localparam logic [LAG_WIDTH-1:0] LAG_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_MARK,
      S_WAIT_ECHO
   } state_t;

   state_t                state_q, state_d;
   logic [LAG_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] probe_data_q, probe_data_d;
   logic                  probe_valid_q, probe_valid_d;
   logic [LAG_WIDTH-1:0]  lag_q, lag_d;
   logic                  lag_valid_q, lag_valid_d;
   logic                  timeout_q, timeout_d;
   logic                  busy_q, busy_d;
   logic                  match;

   assign match = echo_valid && (echo_data == MARKER);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         probe_data_q  <= '0;
         probe_valid_q <= 1'b0;
         lag_q         <= '0;
         lag_valid_q   <= 1'b0;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         probe_data_q  <= probe_data_d;
         probe_valid_q <= probe_valid_d;
         lag_q         <= lag_d;
         lag_valid_q   <= lag_valid_d;
         timeout_q     <= timeout_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      probe_data_d  = probe_data_q;
      probe_valid_d = 1'b0;
      lag_d         = lag_q;
      lag_valid_d   = 1'b0;
      timeout_d     = 1'b0;
      busy_d        = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d  = '0;
               busy_d = 1'b1;
`ifdef FIFO8_LAG_PROBE_PRIME_EN
               state_d = S_PRIME;
`else
               state_d = S_MARK;
`endif
            end
         end
`ifdef FIFO8_LAG_PROBE_PRIME_EN
         S_PRIME: begin
            if (tick) begin
               probe_valid_d = 1'b1;
               probe_data_d  = FILL;
               if (cnt_q == LAG_MAX) begin
                  cnt_d   = '0;
                  state_d = S_MARK;
               end else begin
                  cnt_d = cnt_q + LAG_WIDTH'(1);
               end
            end
         end
`endif
         S_MARK: begin
            // Echoes are not inspected here, so a marker looping straight back is not yet counted.
            if (tick) begin
               probe_valid_d = 1'b1;
               probe_data_d  = MARKER;
               cnt_d         = '0;
               state_d       = S_WAIT_ECHO;
            end
         end
         S_WAIT_ECHO: begin
            // A match takes priority over the timeout on the final tick.
            if (match) begin
               lag_d       = cnt_q;
               lag_valid_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (tick) begin
               if (cnt_q == LAG_MAX) begin
                  lag_d     = LAG_MAX;
                  timeout_d = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  probe_valid_d = 1'b1;
                  probe_data_d  = FILL;
                  cnt_d         = cnt_q + LAG_WIDTH'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign probe_data  = probe_data_q;
   assign probe_valid = probe_valid_q;
   assign lag         = lag_q;
   assign lag_valid   = lag_valid_q;
   assign timeout     = timeout_q;
   assign busy        = busy_q;

endmodule

// File: doc/fifo8_lag_probe.md
# fifo8_lag_probe

Initiator/responder counterpart of the xpu sample delay line: drives a known probe stream into a delay path (tx side) and watches the returned stream (rx side) to measure the path's lag in valid samples. The xpu uses it at bring-up and after any `delay_ctl` change to confirm the programmed delay end-to-end before the delayed stream is trusted. The block sits beside the delay line. Its `probe_*` outputs feed the delay line's `data_in`/`data_in_valid`, and the delay line's `data_out`/`data_out_valid` return on `echo_*`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: sample width.
- `LAG_WIDTH`, default 7: lag counter width. `LAG_MAX` = 2^LAG_WIDTH − 1 = 127.
- `MARKER`, default 8'hA5: probe marker value.
- `FILL`, default 8'h00: filler value. It must differ from `MARKER`.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request. It is ignored unless the block is in IDLE.
- `tick` in 1: sample strobe. At most one probe sample is sent per cycle in which `tick`=1.
- `probe_data` out DATA_WIDTH: sample to the delay-path input.
- `probe_valid` out 1: qualifies `probe_data`.
- `echo_data` in DATA_WIDTH: delay-path output.
- `echo_valid` in 1: qualifies `echo_data`.
- `lag` out LAG_WIDTH: measured lag. It holds its value until the next result.
- `lag_valid` out 1: one-cycle pulse when a measurement completes.
- `timeout` out 1: one-cycle pulse when no marker is seen within `LAG_MAX` samples.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, PRIME, MARK, WAIT_ECHO. All outputs are registered.
- Reset: clears state to IDLE, `probe_data`=0, `probe_valid`=0, `lag`=0, `lag_valid`=0, `timeout`=0, `busy`=0, `cnt`=0. A reset that arrives mid-measurement abandons it; no result pulse is produced.
- IDLE:
  - `start`=1 → `cnt`<=0.
  - Next state is PRIME (macro defined) or MARK (macro undefined).
- PRIME: on each `tick`, emit `FILL` and increment `cnt`. When `tick`=1 and `cnt`=`LAG_MAX` → `cnt`<=0 and next state is MARK. This sends 2^LAG_WIDTH fill samples in total, flushing stale markers from the path.
- MARK: on the first `tick`, emit `MARKER`, set `cnt`<=0 and go to WAIT_ECHO.
- WAIT_ECHO:
  - On each `tick`, emit `FILL` and increment `cnt`.
  - Match condition: `echo_valid`=1 and `echo_data`=`MARKER`. A match is evaluated every cycle regardless of `tick`.
  - On a match: `lag`<=`cnt` (value before any increment in that cycle), `lag_valid`<=1, `probe_valid`<=0, next state IDLE.
  - On `tick`=1 with `cnt`=`LAG_MAX` and no match: `lag`<=`LAG_MAX`, `timeout`<=1, `probe_valid`<=0, next state IDLE.
  - Match and timeout in the same cycle: the match wins.
- Echo matches outside WAIT_ECHO are ignored. This includes a marker echo arriving in the same cycle the marker is sent from MARK.
- Arithmetic: `cnt` is LAG_WIDTH bits. Wrap-around never occurs; the `LAG_MAX` checks terminate PRIME and WAIT_ECHO first.
- `start` while `busy`=1 is dropped, not queued.

## Timing
- `probe_valid`=`tick` registered one cycle later, while in PRIME, MARK or WAIT_ECHO (excluding the exit cycle). `probe_data` updates only when `probe_valid` is driven high; otherwise it holds.
- `busy` rises the cycle after the accepted `start`. It falls in the same cycle that `lag_valid` or `timeout` pulses.
- Zero-lag path (`echo` = `probe` combinationally): the marker is visible at `echo` while in WAIT_ECHO with `cnt`=0 → `lag`=0.
- Path of N valid-sample delay: the marker returns after N further ticks → `lag`=N, for 0 ≤ N < `LAG_MAX`.
- Measurement latency with `tick`=1 continuously and the macro undefined: `lag_valid` arrives N+3 cycles after `start`.

## Configuration
- `FIFO8_LAG_PROBE_PRIME_EN` defined: the PRIME state is compiled in. 128 `FILL` samples (default `LAG_WIDTH`) precede the marker.
- Undefined: the PRIME logic is absent. IDLE goes directly to MARK, and a stale `MARKER` left in the path can produce a short `lag`.

## Test plan
- Macro undefined, `tick`=1, combinational loopback, `start` pulse → one `MARKER` sent, `lag_valid` pulse with `lag`=0, `busy` back to 0.
- Bench delay of N=10 valid samples, `tick`=1 → `lag`=10, `lag_valid` 13 cycles after `start`, `timeout`=0.
- Same N=10 with `tick` high every third cycle → `lag`=10, and `probe_valid` asserts only in the cycle following each `tick`.
- Echo path disconnected (`echo_valid`=0) → `timeout` pulse after 128 ticks in WAIT_ECHO, `lag`=127, `lag_valid` never asserts.
- Macro defined, path preloaded with a stale `MARKER`, N=5 → 128 `FILL` samples precede the marker, stale echo ignored, `lag`=5.
- `start` pulsed while `busy`=1, then `rstn` low mid-WAIT_ECHO → second `start` ignored. After reset, all outputs are 0 and no `lag_valid` or `timeout` pulse occurs.
